// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address width, fixed register indices.
// Optional feature macro used by regfile_mp / regfile_scoreboard: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned ZERO_REG     = 0;
    localparam int unsigned LINK_REG_DEF = 31;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by committed writes.
// With REGFILE_BYPASS_EN defined, busy lookups also see this cycle's clearing writes.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2,
    localparam int unsigned AW    = addr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_en,
    input  logic [AW-1:0]      set_addr,
    input  logic [DEPTH-1:0]   clr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]  rd_busy
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [DEPTH-1:0] set_hit;

    always_comb begin
        set_hit = '0;
        if (set_en) begin
            set_hit[set_addr] = 1'b1;
        end
        set_hit[ZERO_REG] = 1'b0;
        // a new producer issued in the same cycle supersedes the clearing write
        pending_d = set_hit | (pending_q & ~clr);
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
            rd_busy[i] = pending_q[rd_addr[i*AW +: AW]]
                         & ~(clr[rd_addr[i*AW +: AW]] & ~set_hit[rd_addr[i*AW +: AW]]);
`else
            rd_busy[i] = pending_q[rd_addr[i*AW +: AW]];
`endif
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with link write port and pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through on read data and busy flags.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned LINK_REG = LINK_REG_DEF,
    localparam int unsigned AW      = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     link_en,
    input  logic [DATA_W-1:0]        link_data,
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  commit;
    logic [DATA_W-1:0] commit_data [DEPTH];

    // Per-register resolver: later ports override earlier ones, link overrides all.
    for (genvar g = 0; g < DEPTH; g++) begin : g_resolve
        logic              hit;
        logic [DATA_W-1:0] data;

        always_comb begin
            hit  = 1'b0;
            data = '0;
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(g))) begin
                    hit  = 1'b1;
                    data = wr_data[p*DATA_W +: DATA_W];
                end
            end
            if (link_en && (LINK_REG == g)) begin
                hit  = 1'b1;
                data = link_data;
            end
            if (g == ZERO_REG) begin
                hit = 1'b0;
            end
        end

        assign commit[g]      = hit;
        assign commit_data[g] = data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (commit[r]) begin
                    regs_q[r] <= commit_data[r];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i*AW +: AW] != AW'(ZERO_REG)) begin
`ifdef REGFILE_BYPASS_EN
                rd_data[i*DATA_W +: DATA_W] = commit[rd_addr[i*AW +: AW]]
                                              ? commit_data[rd_addr[i*AW +: AW]]
                                              : regs_q[rd_addr[i*AW +: AW]];
`else
                rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*AW +: AW]];
`endif
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set_en),
        .set_addr (sb_set_addr),
        .clr      (commit),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (link at r31 and at r7) share all stimulus.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data_a, rd_data_b;
    logic [1:0]    rd_busy_a, rd_busy_b;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic          link_en;
    logic [DW-1:0] link_data;
    logic          sb_set_en;
    logic [AW-1:0] sb_set_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .LINK_REG(31)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en),
        .link_data(link_data), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
    );

    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .LINK_REG(7)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en),
        .link_data(link_data), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        link_en = 1'b0; link_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    // commit at the next rising edge, then return all write-side inputs to idle
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [DW-1:0] rda(input int p);
        return rd_data_a[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rdb(input int p);
        return rd_data_b[p*DW +: DW];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rd_addr = '0;
        set_rd(0, 5'd5);
        set_rd(1, 5'd31);
        #12;
        chk("reset_rd0", rda(0), 32'h0);
        chk("reset_rd1", rda(1), 32'h0);
        chk("reset_busy", {30'h0, rd_busy_a}, 32'h0);
        rst_n = 1'b1;

        // write r5 and mark it pending, then async reset mid-cycle
        set_wr(0, 5'd5, 32'h0000_DEAD);
        sb_set_en = 1'b1; sb_set_addr = 5'd5;
        step();
        chk("r5_written", rda(0), 32'h0000_DEAD);
        chk("r5_busy_set", {31'h0, rd_busy_a[0]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("r5_async_rst", rda(0), 32'h0);
        chk("r5_busy_rst", {31'h0, rd_busy_a[0]}, 32'h0);
        #1 rst_n = 1'b1;

        // zero register: write and scoreboard set both ignored
        set_rd(0, 5'd0);
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        step();
        chk("r0_data", rda(0), 32'h0);
        chk("r0_busy", {31'h0, rd_busy_a[0]}, 32'h0);

        // collision: higher write port wins
        set_rd(0, 5'd7);
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        step();
        chk("coll_a_r7", rda(0), 32'h22);
        chk("coll_b_r7", rdb(0), 32'h22);

        // only port0 enabled: disabled port1 to the same address must not interfere
        set_wr(0, 5'd7, 32'h99);
        set_wr(1, 5'd7, 32'hEE);
        wr_en[1] = 1'b0;
        step();
        chk("port0_only_r7", rda(0), 32'h99);

        // link beats both ports on b (link=r7); on a link goes to r31 independently
        set_wr(0, 5'd7, 32'h33);
        set_wr(1, 5'd7, 32'h44);
        link_en = 1'b1; link_data = 32'h77;
        step();
        chk("coll_a_r7_link", rda(0), 32'h44);
        chk("coll_a_r31_link", rda(1), 32'h77);
        chk("coll_b_r7_link", rdb(0), 32'h77);

        // scoreboard on r9
        set_rd(0, 5'd9);
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        #1;
        chk("sb_r9_not_yet", {31'h0, rd_busy_a[0]}, 32'h0);
        step();
        chk("sb_r9_busy", {31'h0, rd_busy_a[0]}, 32'h1);
        chk("sb_r9_data0", rda(0), 32'h0);
        set_wr(0, 5'd9, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("sb_r9_bypass_busy", {31'h0, rd_busy_a[0]}, 32'h0);
        chk("sb_r9_bypass_data", rda(0), 32'h55);
`else
        chk("sb_r9_busy_hold", {31'h0, rd_busy_a[0]}, 32'h1);
        chk("sb_r9_data_hold", rda(0), 32'h0);
`endif
        step();
        chk("sb_r9_cleared", {31'h0, rd_busy_a[0]}, 32'h0);
        chk("sb_r9_data55", rda(0), 32'h55);
        set_wr(1, 5'd9, 32'h66);
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        #1;
        chk("sb_r9_setwr_comb", {31'h0, rd_busy_a[0]}, 32'h0);
        step();
        chk("sb_r9_set_wins", {31'h0, rd_busy_a[0]}, 32'h1);
        chk("sb_r9_data66", rda(0), 32'h66);

        // link write alongside a port write to a different register; link also clears pending r31
        set_rd(0, 5'd3);
        set_rd(1, 5'd31);
        sb_set_en = 1'b1; sb_set_addr = 5'd31;
        step();
        chk("r31_pending", {31'h0, rd_busy_a[1]}, 32'h1);
        link_en = 1'b1; link_data = 32'h0040_0008;
        set_wr(0, 5'd3, 32'h1);
        step();
        chk("link_a_r31", rda(1), 32'h0040_0008);
        chk("link_a_r3", rda(0), 32'h1);
        chk("link_a_r31_clr", {31'h0, rd_busy_a[1]}, 32'h0);
        chk("link_b_r3", rdb(0), 32'h1);
        set_rd(0, 5'd7);
        #1;
        chk("link_b_r7", rdb(0), 32'h0040_0008);

        // link alone, no general write enabled
        link_en = 1'b1; link_data = 32'h1234;
        step();
        chk("link_only_a_r31", rda(1), 32'h1234);
        chk("link_only_b_r7", rdb(0), 32'h1234);

        // same-cycle read of a register being written
        set_rd(0, 5'd4);
        set_wr(0, 5'd4, 32'hABCD);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_r4", rda(0), 32'hABCD);
`else
        chk("nobypass_r4", rda(0), 32'h0);
`endif
        step();
        chk("r4_stored", rda(0), 32'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
